// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: envelope state encoding and sample timing.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int unsigned SAMPLE_DIV_DEFAULT = 2000;
  localparam int unsigned ENV_W              = 16;
  localparam logic [15:0] ENV_MAX            = 16'hFFFF;

endpackage

// File: rtl/env_amp_if.sv
// Sample-stream, key-gate and envelope-control bundle between a voice controller and env_amp.
interface env_amp_if;

  logic               gate;
  logic signed [15:0] din;
  logic        [15:0] attack_rate;
  logic        [15:0] decay_rate;
  logic        [15:0] sustain_lvl;
  logic        [15:0] release_rate;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic        [2:0]  env_state;

  modport master (
    output gate, din, attack_rate, decay_rate, sustain_lvl, release_rate,
    input  dout, dout_valid, env_state
  );

  modport slave (
    input  gate, din, attack_rate, decay_rate, sustain_lvl, release_rate,
    output dout, dout_valid, env_state
  );

endinterface

// File: rtl/sample_tick.sv
// Free-running sample-rate divider; tick is high for the last clock of each sample period.
module sample_tick #(
  parameter int unsigned SAMPLE_DIV = 2000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/env_amp.sv
// ADSR envelope amplitude stage: one envelope step per sample tick, 2-clock multiply pipeline.
// Define ENV_EXP_RELEASE_EN for exponential release (env -= env >> release_rate[3:0]).
module env_amp
  import synth_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input logic      clk96M,
  input logic      reset,
  env_amp_if.slave bus
);

  logic tick;

  sample_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sample_tick (
    .clk  (clk96M),
    .reset(reset),
    .tick (tick)
  );

  env_state_t       state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic             gate_q;
  logic             rise, fall;

  assign rise = bus.gate & ~gate_q;
  assign fall = ~bus.gate & gate_q;

  // 17-bit intermediates expose carry/borrow so nothing can wrap.
  logic [ENV_W:0] sum, diff_dec, diff_rel;
  logic           attack_done, decay_done, rel_done;

  assign sum        = {1'b0, env_q} + {1'b0, bus.attack_rate};
  assign diff_dec   = {1'b0, env_q} - {1'b0, bus.decay_rate};
  assign attack_done = (bus.attack_rate == '0) | sum[ENV_W] | (sum[ENV_W-1:0] == ENV_MAX);
  assign decay_done  = (bus.decay_rate == '0) | diff_dec[ENV_W] |
                       (diff_dec[ENV_W-1:0] <= bus.sustain_lvl);

`ifdef ENV_EXP_RELEASE_EN
  logic [3:0] rel_shift;
  logic       unused_rel_rate;

  assign rel_shift       = (bus.release_rate[3:0] == 4'd0) ? 4'd1 : bus.release_rate[3:0];
  assign diff_rel        = {1'b0, env_q} - {1'b0, env_q >> rel_shift};
  assign rel_done        = (diff_rel[ENV_W:4] == '0);
  assign unused_rel_rate = ^bus.release_rate[15:4];
`else
  assign diff_rel = {1'b0, env_q} - {1'b0, bus.release_rate};
  assign rel_done = (bus.release_rate == '0) | diff_rel[ENV_W] | (diff_rel[ENV_W-1:0] == '0);
`endif

  // Gate edges win over rate evaluation; env is held so a retrigger never clicks.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
      state_d = RELEASE;
    end else begin
      case (state_q)
        ATTACK: begin
          if (attack_done) begin
            env_d   = ENV_MAX;
            state_d = DECAY;
          end else begin
            env_d = sum[ENV_W-1:0];
          end
        end
        DECAY: begin
          if (decay_done) begin
            env_d   = bus.sustain_lvl;
            state_d = SUSTAIN;
          end else begin
            env_d = diff_dec[ENV_W-1:0];
          end
        end
        SUSTAIN: env_d = bus.sustain_lvl;
        RELEASE: begin
          if (rel_done) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = diff_rel[ENV_W-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk96M or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      env_q   <= '0;
      gate_q  <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      env_q   <= env_d;
      gate_q  <= bus.gate;
    end
  end

  logic signed [15:0] din_q;
  logic               cap_q;
  logic signed [32:0] din_ext, env_ext, prod_q;
  logic               prod_vld_q;
  logic signed [15:0] dout_q;
  logic               dout_valid_q;
  logic               unused_prod;

  assign din_ext     = {{17{din_q[15]}}, din_q};
  assign env_ext     = {17'd0, env_q};
  assign unused_prod = ^{prod_q[32], prod_q[15:0]};

  always_ff @(posedge clk96M or negedge reset) begin
    if (!reset) begin
      din_q        <= '0;
      cap_q        <= 1'b0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cap_q        <= tick;
      prod_vld_q   <= cap_q;
      dout_valid_q <= prod_vld_q;
      if (tick) begin
        din_q <= bus.din;
      end
      if (cap_q) begin
        prod_q <= din_ext * env_ext;
      end
      if (prod_vld_q) begin
        dout_q <= prod_q[31:16];
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.env_state  = state_q;

endmodule

// File: tb/tb_env_amp.sv
// Bench for env_amp: per-tick ADSR reference model checked every cycle, plus directed literals.
module tb_env_amp;
  import synth_pkg::*;

  localparam int unsigned DIV = 20;

  logic clk96M = 1'b0;
  logic reset  = 1'b1;
  logic cmp_en = 1'b0;

  env_amp_if bus ();

  env_amp #(
    .SAMPLE_DIV(DIV)
  ) dut (
    .clk96M(clk96M),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk96M = ~clk96M;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: envelope rules applied once per sample, output due two edges later.
  int          m_env   = 0;
  int          m_state = 0;
  int          m_gate_q = 0;
  longint      m_n     = 0;
  longint      m_due   = -1;
  logic [15:0] m_pend  = '0;
  logic [15:0] m_dout  = '0;
  logic        m_valid = 1'b0;

  task automatic model_tick();
    bit     rise, fall;
    int     ar, dr, sus, rr, e, sh;
    longint p;
    rise = bus.gate && (m_gate_q == 0);
    fall = !bus.gate && (m_gate_q != 0);
    ar  = int'(bus.attack_rate);
    dr  = int'(bus.decay_rate);
    sus = int'(bus.sustain_lvl);
    rr  = int'(bus.release_rate);
    if (rise) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    else if (m_state == 1) begin
      if (ar == 0 || m_env + ar >= 65535) begin m_env = 65535; m_state = 2; end
      else m_env = m_env + ar;
    end else if (m_state == 2) begin
      e = m_env - dr;
      if (dr == 0 || e <= sus) begin m_env = sus; m_state = 3; end
      else m_env = e;
    end else if (m_state == 3) begin
      m_env = sus;
    end else if (m_state == 4) begin
`ifdef ENV_EXP_RELEASE_EN
      sh = rr % 16;
      if (sh == 0) sh = 1;
      e = m_env - (m_env >> sh);
      if (e < 16) begin m_env = 0; m_state = 0; end
      else m_env = e;
`else
      sh = 0;
      e = m_env - rr;
      if (rr == 0 || e <= 0) begin m_env = 0; m_state = 0; end
      else m_env = e;
`endif
    end else begin
      m_env = 0;
    end
    m_gate_q = bus.gate ? 1 : 0;
    p = longint'(bus.din) * longint'(m_env);
    m_pend = 16'(p >>> 16);
    m_due  = m_n + 2;
  endtask

  initial forever begin
    @(posedge clk96M or negedge reset);
    if (!reset) begin
      m_env = 0; m_state = 0; m_gate_q = 0; m_n = 0; m_due = -1;
      m_dout = '0; m_valid = 1'b0;
    end else begin
      m_n++;
      m_valid = (m_n == m_due);
      if (m_valid) m_dout = m_pend;
      if (m_n % DIV == 0) model_tick();
    end
  end

  initial forever begin
    @(negedge clk96M);
    if (cmp_en) begin
      check("model_dout", {16'h0, bus.dout}, {16'h0, m_dout});
      check("model_valid", {31'h0, bus.dout_valid}, {31'h0, m_valid});
      check("model_state", {29'h0, bus.env_state}, m_state);
    end
  end

  task automatic wait_tick(input int k);
    repeat (k * DIV) @(negedge clk96M);
  endtask

  task automatic wait_idle(input string name, input int max_ticks);
    for (int i = 0; i < max_ticks; i++) begin
      if (bus.env_state == 3'd0) break;
      wait_tick(1);
    end
    check(name, {29'h0, bus.env_state}, 32'd0);
  endtask

  initial begin
    int t;
    bus.gate         = 1'b1;
    bus.din          = 16'sh4000;
    bus.attack_rate  = 16'h1000;
    bus.decay_rate   = 16'h0100;
    bus.sustain_lvl  = 16'h8000;
    bus.release_rate = 16'h0400;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (4) @(negedge clk96M);
    check("reset_dout", {16'h0, bus.dout}, 32'h0);
    check("reset_valid", {31'h0, bus.dout_valid}, 32'h0);
    check("reset_state", {29'h0, bus.env_state}, 32'h0);

    // Attack / decay / sustain timing
    bus.din = 16'sh7FFF;
    reset   = 1'b1;
    wait_tick(1);   check("first_tick_attack", {29'h0, bus.env_state}, 32'd1);
    wait_tick(15);  check("attack_tick15", {29'h0, bus.env_state}, 32'd1);
    wait_tick(1);   check("attack_sat_tick16", {29'h0, bus.env_state}, 32'd2);
    wait_tick(127); check("decay_tick127", {29'h0, bus.env_state}, 32'd2);
    wait_tick(1);   check("sustain_tick128", {29'h0, bus.env_state}, 32'd3);
    wait_tick(2);   check("sustain_dout", {16'h0, bus.dout}, 32'h3FFF);

    t = 0;
    while (!bus.dout_valid && t < 2 * DIV) begin @(negedge clk96M); t++; end
    check("valid_offset", t, 32'd2);
    t = 0;
    do begin @(negedge clk96M); t++; end while (!bus.dout_valid && t < 2 * DIV);
    check("valid_period", t, DIV);
    repeat (DIV - 2) @(negedge clk96M);

`ifndef ENV_EXP_RELEASE_EN
    bus.gate = 1'b0;
    wait_tick(1);  check("rel_enter", {29'h0, bus.env_state}, 32'd4);
    wait_tick(31); check("rel_tick31", {29'h0, bus.env_state}, 32'd4);
    wait_tick(1);  check("rel_idle_tick32", {29'h0, bus.env_state}, 32'd0);
    wait_tick(1);  check("rel_dout_zero", {16'h0, bus.dout}, 32'h0);
`else
    bus.gate         = 1'b0;
    bus.release_rate = 16'h0004;
    wait_tick(1); check("exp_rel_enter", {29'h0, bus.env_state}, 32'd4);
    wait_tick(2); check("exp_rel_first_step", {16'h0, bus.dout}, 32'h3BFF);
    wait_idle("exp_rel_idle", 400);
    bus.release_rate = 16'h0400;
`endif

    // Retrigger mid-release, negative sample
    bus.gate = 1'b1;
    wait_tick(147); check("retrig_sustain", {29'h0, bus.env_state}, 32'd3);
    bus.gate = 1'b0;
    wait_tick(17);
`ifndef ENV_EXP_RELEASE_EN
    check("retrig_in_release", {29'h0, bus.env_state}, 32'd4);
`endif
    bus.gate = 1'b1;
    bus.din  = 16'sh8000;
    wait_tick(1); check("retrig_attack", {29'h0, bus.env_state}, 32'd1);
    wait_tick(1);
`ifndef ENV_EXP_RELEASE_EN
    check("retrig_dout_env4000", {16'h0, bus.dout}, 32'hE000);
`endif
    wait_tick(1);
`ifndef ENV_EXP_RELEASE_EN
    check("retrig_dout_env5000", {16'h0, bus.dout}, 32'hD800);
`endif

    // Zero rates: every phase instant
    bus.attack_rate  = 16'h0;
    bus.decay_rate   = 16'h0;
    bus.release_rate = 16'h0;
    bus.sustain_lvl  = 16'h2000;
    bus.gate         = 1'b0;
    wait_idle("zero_to_idle", 40);
    bus.gate = 1'b1;
    wait_tick(1); check("zero_attack", {29'h0, bus.env_state}, 32'd1);
    wait_tick(1); check("zero_decay", {29'h0, bus.env_state}, 32'd2);
    wait_tick(1); check("zero_sustain", {29'h0, bus.env_state}, 32'd3);
    wait_tick(1); check("zero_sustain_dout", {16'h0, bus.dout}, 32'hF000);
    bus.sustain_lvl = 16'h4000;
    wait_tick(2); check("sustain_tracks_live", {16'h0, bus.dout}, 32'hE000);
    bus.gate = 1'b0;
    wait_tick(1); check("zero_release", {29'h0, bus.env_state}, 32'd4);
`ifndef ENV_EXP_RELEASE_EN
    wait_tick(1); check("zero_release_idle", {29'h0, bus.env_state}, 32'd0);
`endif
    wait_idle("zero_idle_final", 40);

    // Reset mid-note, then gate still high counts as a fresh rising edge
    bus.attack_rate = 16'h1000;
    bus.gate        = 1'b1;
    wait_tick(2);
    #3 reset = 1'b0;
    #1;
    check("midreset_state", {29'h0, bus.env_state}, 32'd0);
    check("midreset_dout", {16'h0, bus.dout}, 32'h0);
    check("midreset_valid", {31'h0, bus.dout_valid}, 32'h0);
    repeat (3) @(negedge clk96M);
    reset = 1'b1;
    wait_tick(1); check("post_reset_attack", {29'h0, bus.env_state}, 32'd1);
    wait_tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
